// File: rtl/dmem_pkg.sv
// Core-wide constants shared by the datapath blocks of the single-cycle RISC-V core.
package dmem_pkg;

    localparam int XLEN            = 32;
    localparam int DMEM_DEPTH_LOG2 = 8;

endpackage

// File: rtl/dmem.sv
// Word-addressed data memory: synchronous writes and reset-clear, combinational reads gated by MemRead.
import dmem_pkg::*;

module dmem #(
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [XLEN-1:0]       addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic                  unusedAddrBits;

    // Byte offset and the bits above the array size are dropped, so
    // misaligned accesses hit the enclosing word and addresses wrap.
    assign wordIdx        = addr[DEPTH_LOG2+1:2];
    assign unusedAddrBits = ^{addr[XLEN-1:DEPTH_LOG2+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite) begin
            mem_q[wordIdx] <= WriteData;
        end
    end

    // No bypass: a same-cycle write becomes visible only after the edge.
    assign ReadData = MemRead ? mem_q[wordIdx] : '0;

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: a word-array reference model checked every cycle plus literal spot checks.
module tb_dmem;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] modelMem [256];
    bit          modelValid = 0;

    dmem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .WriteData(WriteData),
        .ReadData (ReadData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: 256 words indexed by byte address / 4, wrapping at 1 KiB.
    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % 32'd256);
    endfunction

    function automatic logic [31:0] expectedRead();
        if (!MemRead) return 32'h0;
        return modelMem[wordOf(addr)];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
                modelValid = 1'b1;
            end else if (MemWrite) begin
                modelMem[wordOf(addr)] = WriteData;
            end
        end
    end

    // Every cycle once the array has been reset, ReadData must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid) begin
                logic [31:0] exp;
                exp = expectedRead();
                nCompared++;
                if (ReadData !== exp) begin
                    nMismatched++;
                    $display("[TB] FAIL model addr=%h rd=%0b wr=%0b: got %h expected %h",
                             addr, MemRead, MemWrite, ReadData, exp);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rstN, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] wd);
        rst_n     = rstN;
        MemRead   = rd;
        MemWrite  = wr;
        addr      = a;
        WriteData = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] required);
        nCompared++;
        if (ReadData !== required) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h required %h", name, ReadData, required);
        end
    endtask

    task automatic writeWord(input logic [31:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, 1'b1, a, wd);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] required);
        applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
        checkOutput(name, required);
        tick();
    endtask

    initial begin
        // Reset edge with a write pending: the write must be dropped.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h08, 32'hFFFF_FFFF);
        tick();
        readCheck("reset_0x00",  32'h000, 32'h0);
        readCheck("reset_0x08",  32'h008, 32'h0);
        readCheck("reset_0x3FC", 32'h3FC, 32'h0);

        writeWord(32'h08, 32'hABCD_1234);
        readCheck("write_read_0x08", 32'h08, 32'hABCD_1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
        checkOutput("memread_low", 32'h0);
        tick();

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h08, 32'h5555_5555);
        tick();
        readCheck("reset_clears_0x08", 32'h08, 32'h0);

        writeWord(32'h0A, 32'hDEAD_BEEF);
        readCheck("misaligned_0x0A_to_0x08", 32'h08, 32'hDEAD_BEEF);
        writeWord(32'h40C, 32'h1234_5678);
        readCheck("alias_0x40C_to_0x00C", 32'h00C, 32'h1234_5678);
        readCheck("alias_high_bits", 32'hFFFF_FC0C, 32'h1234_5678);

        writeWord(32'h10, 32'h1111_1111);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h2222_2222);
        checkOutput("rdw_before_edge", 32'h1111_1111);
        tick();
        checkOutput("rdw_after_edge", 32'h2222_2222);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        writeWord(32'h000, 32'hA0A0_0000);
        writeWord(32'h004, 32'hA1A1_0001);
        writeWord(32'h3FC, 32'hAFAF_00FF);
        readCheck("indep_word0",   32'h000, 32'hA0A0_0000);
        readCheck("indep_word1",   32'h004, 32'hA1A1_0001);
        readCheck("indep_word255", 32'h3FC, 32'hAFAF_00FF);
        readCheck("indep_word2",   32'h008, 32'h0);
        readCheck("indep_word254", 32'h3F8, 32'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
